// File: rtl/yuv_mb_fetch.sv
// yuv_mb_fetch
// Pulls one 16x16 4:2:0 macroblock at a time from the YUV line-buffer RAM.
// Each macroblock is 96 words: 0..63 luma, 64..95 chroma. The words land in a
// two-bank ping-pong buffer. Each complete bank is offered to the H.264 encoder
// front end, tagged with the coordinates of its macroblock.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   r_valid      : RAM holds a complete macroblock row and may be read
//   r_ready      : one-word read request this cycle
//   r_addr_o     : word index (0..MB_WORDS-1) requested this cycle
//   data_valid   : data_i carries the word for the request accepted last cycle
//   data_i       : returned word
//   mb_valid     : read bank holds a complete macroblock
//   mb_rd_addr   : encoder word index into the read bank
//   mb_rd_data   : registered read data, one cycle after mb_rd_addr
//   mb_done      : encoder has finished with the read bank (single-cycle pulse)
//   mb_x, mb_y   : coordinates of the macroblock in the read bank
//   frame_start  : read bank holds macroblock (0,0)
module yuv_mb_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int MB_WORDS   = 96,
    parameter int ADDR_WIDTH = 7,
    parameter int MB_W       = 80,
    parameter int MB_H       = 45,
    parameter int MBX_WIDTH  = 7,
    parameter int MBY_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_valid,
    output logic                  r_ready,
    output logic [ADDR_WIDTH-1:0] r_addr_o,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  mb_valid,
    input  logic [ADDR_WIDTH-1:0] mb_rd_addr,
    output logic [DATA_WIDTH-1:0] mb_rd_data,
    input  logic                  mb_done,
    output logic [MBX_WIDTH-1:0]  mb_x,
    output logic [MBY_WIDTH-1:0]  mb_y,
    output logic                  frame_start
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MB_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] NUM_WORDS = ADDR_WIDTH'(MB_WORDS);
    localparam logic [MBX_WIDTH-1:0]  LAST_X    = MBX_WIDTH'(MB_W - 1);
    localparam logic [MBY_WIDTH-1:0]  LAST_Y    = MBY_WIDTH'(MB_H - 1);

    logic [1:0]                 state;
    logic [ADDR_WIDTH-1:0]      req_cnt;
    logic [ADDR_WIDTH-1:0]      ret_cnt;
    logic                       req_pending;
    logic [1:0]                 full;
    logic                       wr_bank;
    logic                       rd_bank;
    logic [MBX_WIDTH-1:0]       fetch_x;
    logic [MBY_WIDTH-1:0]       fetch_y;
    logic [1:0][MBX_WIDTH-1:0]  tag_x;
    logic [1:0][MBY_WIDTH-1:0]  tag_y;
    logic [DATA_WIDTH-1:0]      buffer [2][MB_WORDS];

    logic accept;
    logic wr_en;
    logic last_write;
    logic release_bank;

    // The FETCH state acts as a registered enable. It is gated by r_valid so
    // that a dropped r_valid stops requests in the same cycle.
    assign r_ready  = (state == FETCH) && r_valid;
    assign r_addr_o = req_cnt;
    assign accept   = r_ready;

    // Only a word answering a request accepted on the previous edge is stored.
    // Any other data_valid is a stray and is dropped.
    assign wr_en        = data_valid && req_pending;
    assign last_write   = wr_en && (ret_cnt == LAST_WORD);
    assign release_bank = mb_done && full[rd_bank];

    assign mb_valid    = full[rd_bank];
    assign mb_x        = tag_x[rd_bank];
    assign mb_y        = tag_y[rd_bank];
    assign frame_start = mb_valid && (tag_x[rd_bank] == '0) && (tag_y[rd_bank] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_cnt     <= '0;
            req_pending <= 1'b0;
        end else begin
            req_pending <= accept;
            if (accept) begin
                req_cnt <= (req_cnt == LAST_WORD) ? '0 : req_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (r_valid && !full[wr_bank]) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (accept && (req_cnt == LAST_WORD)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_write) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completing a bank and releasing a bank may coincide. They always touch
    // different banks, because a fetch only starts into a bank that is not full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_cnt <= '0;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            fetch_x <= '0;
            fetch_y <= '0;
            tag_x   <= '0;
            tag_y   <= '0;
        end else begin
            if (wr_en) begin
                ret_cnt <= last_write ? '0 : ret_cnt + 1'b1;
            end
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (last_write) begin
                full[wr_bank]  <= 1'b1;
                tag_x[wr_bank] <= fetch_x;
                tag_y[wr_bank] <= fetch_y;
                wr_bank        <= ~wr_bank;
                if (fetch_x == LAST_X) begin
                    fetch_x <= '0;
                    fetch_y <= (fetch_y == LAST_Y) ? '0 : fetch_y + 1'b1;
                end else begin
                    fetch_x <= fetch_x + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_bank][ret_cnt] <= data_i;
        end
    end

    // The encoder read port is free-running. Indices past the macroblock read as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_rd_data <= '0;
        end else if (mb_rd_addr < NUM_WORDS) begin
            mb_rd_data <= buffer[rd_bank][mb_rd_addr];
        end else begin
            mb_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_yuv_mb_fetch.sv
// tb_yuv_mb_fetch
// Self-checking bench for yuv_mb_fetch. It contains:
//  - a RAM model that answers every accepted request one cycle later;
//  - an encoder model that reads and releases macroblocks in order.
// The expected word contents and macroblock tags come from the macroblock's
// ordinal position in the stream. The picture is shrunk to 5x3 macroblocks so
// that both the row wrap and the frame wrap are reached quickly.
module tb_yuv_mb_fetch;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int WORDS = 96;
    localparam int W     = 5;
    localparam int H     = 3;
    localparam int XW    = 7;
    localparam int YW    = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r_valid = 1'b0;
    logic          r_ready;
    logic [AW-1:0] r_addr_o;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          mb_valid;
    logic [AW-1:0] mb_rd_addr = '0;
    logic [DW-1:0] mb_rd_data;
    logic          mb_done = 1'b0;
    logic [XW-1:0] mb_x;
    logic [YW-1:0] mb_y;
    logic          frame_start;

    int compared = 0;
    int mismatched = 0;
    int ram_mb = 0;
    int ram_next = 0;
    int acc_total = 0;
    int seq_err = 0;
    int ready_err = 0;
    int enc = 0;
    bit stray = 1'b0;
    bit dv_last = 1'b0;
    bit rv_random = 1'b0;
    logic [31:0] salt [16];

    yuv_mb_fetch #(
        .DATA_WIDTH(DW), .MB_WORDS(WORDS), .ADDR_WIDTH(AW),
        .MB_W(W), .MB_H(H), .MBX_WIDTH(XW), .MBY_WIDTH(YW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .r_valid(r_valid), .r_ready(r_ready),
        .r_addr_o(r_addr_o), .data_valid(data_valid), .data_i(data_i),
        .mb_valid(mb_valid), .mb_rd_addr(mb_rd_addr), .mb_rd_data(mb_rd_data),
        .mb_done(mb_done), .mb_x(mb_x), .mb_y(mb_y), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Word a of the k-th macroblock since reset. The first macroblock carries
    // its plain word index.
    function automatic logic [31:0] wordOf(input int k, input int a);
        if (k == 0) return 32'(a);
        return salt[k % 16] ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #2;
        if (rv_random) r_valid = ($urandom_range(0, 9) != 0);
    endtask

    // RAM model. A request is accepted when r_valid and r_ready are both high
    // at an edge. The accepted words must walk 0..95 in order and then repeat.
    always @(posedge clk) begin
        bit acc;
        int a;
        logic [31:0] w;
        acc = r_valid && r_ready;
        a = int'(r_addr_o);
        w = '0;
        if (r_ready && !r_valid) ready_err++;
        if (!rst_n) begin
            ram_mb = 0;
            ram_next = 0;
            acc = 1'b0;
        end else if (acc) begin
            acc_total++;
            if (a != ram_next) seq_err++;
            w = wordOf(ram_mb, a);
            ram_next = (ram_next + 1) % WORDS;
            if (ram_next == 0) ram_mb++;
        end
        #1;
        dv_last = acc && (a == WORDS - 1);
        data_valid = acc || stray;
        data_i = acc ? w : (stray ? 32'hDEAD_BEEF : 32'h0);
    end

    task automatic consumeMacroblock(input bit fullCheck, input int doneDelay);
        int n;
        int a;
        n = 0;
        while (!mb_valid && n < 600) begin
            applyStimulus();
            n++;
        end
        checkOutput("mb_valid_wait", 64'(mb_valid), 64'(1));
        if (mb_valid === 1'b1) begin
            checkOutput("mb_x", 64'(mb_x), 64'(enc % W));
            checkOutput("mb_y", 64'(mb_y), 64'((enc / W) % H));
            checkOutput("frame_start", 64'(frame_start), 64'((enc % (W * H)) == 0));
            for (int i = 0; i < (fullCheck ? WORDS : 3); i++) begin
                a = fullCheck ? i : $urandom_range(0, WORDS - 1);
                mb_rd_addr = AW'(a);
                applyStimulus();
                checkOutput("mb_rd_data", 64'(mb_rd_data), 64'(wordOf(enc, a)));
            end
            repeat (doneDelay) applyStimulus();
            mb_done = 1'b1;
            applyStimulus();
            mb_done = 1'b0;
            enc++;
        end
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_r_ready"}, 64'(r_ready), 64'(0));
        checkOutput({phase, "_r_addr"}, 64'(r_addr_o), 64'(0));
        checkOutput({phase, "_mb_valid"}, 64'(mb_valid), 64'(0));
        checkOutput({phase, "_mb_rd_data"}, 64'(mb_rd_data), 64'(0));
        checkOutput({phase, "_mb_x"}, 64'(mb_x), 64'(0));
        checkOutput({phase, "_mb_y"}, 64'(mb_y), 64'(0));
        checkOutput({phase, "_frame_start"}, 64'(frame_start), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rdyCount, dvCount, lastDv, firstMv, quiet, n, gaps;
        for (int i = 0; i < 16; i++) salt[i] = $urandom;

        // Reset state
        #3;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();

        // Single macroblock: 96 requests, mb_valid one cycle after last word
        r_valid = 1'b1;
        rdyCount = 0; dvCount = 0; lastDv = -1; firstMv = -1;
        for (int c = 0; c < 400 && firstMv < 0; c++) begin
            applyStimulus();
            if (mb_valid) firstMv = c;
            else begin
                if (r_ready) rdyCount++;
                if (data_valid) begin
                    dvCount++;
                    if (dvCount == WORDS) lastDv = c;
                end
            end
        end
        checkOutput("mb0_ready_cycles", 64'(rdyCount), 64'(WORDS));
        checkOutput("mb0_valid_latency", 64'(firstMv), 64'(lastDv + 1));
        mb_rd_addr = AW'(37);
        applyStimulus();
        checkOutput("mb0_word37", 64'(mb_rd_data), 64'(37));
        checkOutput("mb0_x", 64'(mb_x), 64'(0));
        checkOutput("mb0_y", 64'(mb_y), 64'(0));
        checkOutput("mb0_frame_start", 64'(frame_start), 64'(1));

        // Ping-pong stall: both banks fill, then no more requests
        quiet = 0;
        for (int c = 0; c < 500; c++) begin
            applyStimulus();
            if (r_ready) quiet = 0; else quiet++;
        end
        checkOutput("stall_mb_count", 64'(ram_mb), 64'(2));
        checkOutput("stall_accepts", 64'(acc_total), 64'(2 * WORDS));
        checkOutput("stall_ready_low", 64'(quiet >= 300), 64'(1));
        checkOutput("stall_x", 64'(mb_x), 64'(0));
        stray = 1'b1;
        applyStimulus();
        stray = 1'b0;
        repeat (2) applyStimulus();
        mb_done = 1'b1;
        applyStimulus();
        mb_done = 1'b0;
        enc = 1;
        checkOutput("release_valid", 64'(mb_valid), 64'(1));
        checkOutput("release_x", 64'(mb_x), 64'(1));
        checkOutput("release_y", 64'(mb_y), 64'(0));
        checkOutput("release_frame_start", 64'(frame_start), 64'(0));

        // r_valid drop at word 40 of the third fetch
        n = 0;
        while (!(r_ready && r_addr_o == AW'(40)) && n < 300) begin
            applyStimulus();
            n++;
        end
        checkOutput("addr40_reached", 64'(r_ready && r_addr_o == AW'(40)), 64'(1));
        r_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("hold_ready", 64'(r_ready), 64'(0));
            checkOutput("hold_addr", 64'(r_addr_o), 64'(40));
        end
        r_valid = 1'b1;
        #1;
        checkOutput("resume_addr", 64'(r_addr_o), 64'(40));
        checkOutput("resume_ready", 64'(r_ready), 64'(1));
        consumeMacroblock(1'b1, 0);
        consumeMacroblock(1'b1, 0);

        // Coincident release and completion: mb_valid never drops
        n = 0;
        while (!mb_valid && n < 300) begin
            applyStimulus();
            n++;
        end
        checkOutput("coinc_pre_x", 64'(mb_x), 64'(enc % W));
        gaps = 0; n = 0;
        while (!(data_valid && dv_last) && n < 400) begin
            applyStimulus();
            n++;
            if (!mb_valid) gaps++;
        end
        checkOutput("coinc_last_seen", 64'(data_valid && dv_last), 64'(1));
        mb_done = 1'b1;
        applyStimulus();
        mb_done = 1'b0;
        if (!mb_valid) gaps++;
        checkOutput("coinc_valid_gaps", 64'(gaps), 64'(0));
        checkOutput("coinc_next_x", 64'(mb_x), 64'((enc + 1) % W));
        checkOutput("coinc_next_y", 64'(mb_y), 64'(((enc + 1) / W) % H));
        enc++;

        // Randomized streaming across row and frame wraps
        rv_random = 1'b1;
        for (int i = 0; i < 32; i++) begin
            consumeMacroblock(1'b0, $urandom_range(0, 6));
        end
        rv_random = 1'b0;
        r_valid = 1'b1;

        // Asynchronous reset while r_addr_o is 50
        consumeMacroblock(1'b0, 0);
        n = 0;
        while (!(r_ready && r_addr_o == AW'(50)) && n < 400) begin
            applyStimulus();
            n++;
        end
        checkOutput("addr50_reached", 64'(r_ready && r_addr_o == AW'(50)), 64'(1));
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        enc = 0;
        repeat (3) applyStimulus();
        rst_n = 1'b1;
        n = 0;
        while (!r_ready && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("restart_ready", 64'(r_ready), 64'(1));
        checkOutput("restart_addr", 64'(r_addr_o), 64'(0));
        consumeMacroblock(1'b1, 0);

        checkOutput("request_sequence_errors", 64'(seq_err), 64'(0));
        checkOutput("ready_without_valid", 64'(ready_err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
